// File: rtl/wtm_mul_arbiter.sv
// wtm_mul_arbiter: round-robin front end for a shared
// pipelined wtm32 multiplier with in-order tagged results.
module wtm_mul_arbiter #(
  parameter int W       = 32,
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 1,
  parameter int IDW     = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [W-1:0]      mul_x,
  output logic [W-1:0]      mul_y,
  input  logic [2*W-1:0]    mul_s,
  output logic              res_valid,
  output logic [IDW-1:0]    res_id,
  output logic [2*W-1:0]    res_p,
  output logic              busy,
  output logic [31:0]       issue_cnt
);

  typedef struct packed {
    logic           v;
    logic [IDW-1:0] id;
  } tag_t;

  localparam logic [IDW:0]   NR   = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] LAST = IDW'(NREQ-1);

  logic [W-1:0]   opa [NREQ];
  logic [W-1:0]   opb [NREQ];
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] gid;
  logic [IDW-1:0] nxt_ptr;
  logic [IDW:0]   sum;
  logic           hit;
  logic           fire;
  logic           inflight;
  tag_t [MUL_LAT-1:0] tag;

  for (genvar i = 0; i < NREQ; i++) begin : g_ops
    assign opa[i] = req_a[i*W +: W];
    assign opb[i] = req_b[i*W +: W];
  end

  // Walk downward so the nearest requester after rr_ptr wins.
  always_comb begin
    gid = '0;
    hit = 1'b0;
    sum = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (sum >= NR) sum = sum - NR;
      if (req_valid[sum[IDW-1:0]]) begin
        hit = 1'b1;
        gid = sum[IDW-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (en && !rst && hit) req_ready[gid] = 1'b1;
  end

  assign fire    = |(req_valid & req_ready);
  assign nxt_ptr = (gid == LAST) ? '0 : gid + 1'b1;

  always_comb begin
    inflight = 1'b0;
    for (int i = 0; i < MUL_LAT; i++) inflight |= tag[i].v;
  end

  assign busy = inflight | res_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      mul_x     <= '0;
      mul_y     <= '0;
      tag       <= '0;
      rr_ptr    <= '0;
      issue_cnt <= '0;
      res_valid <= 1'b0;
      res_id    <= '0;
      res_p     <= '0;
    end else begin
      if (fire) begin
        mul_x     <= opa[gid];
        mul_y     <= opb[gid];
        rr_ptr    <= nxt_ptr;
        issue_cnt <= issue_cnt + 32'd1;
      end
      tag[0] <= '{v: fire, id: gid};
      for (int i = 1; i < MUL_LAT; i++) tag[i] <= tag[i-1];
      res_valid <= tag[MUL_LAT-1].v;
      if (tag[MUL_LAT-1].v) begin
        res_id <= tag[MUL_LAT-1].id;
        res_p  <= mul_s;
      end
    end
  end

endmodule
